// File: rtl/ast_packet_arbiter.sv
// Packet-granular round-robin merge of N_SRC Avalon-ST sources onto one sink; one idle decision cycle per packet.
// Registered output, one cycle input-to-output; source ready falls in the same cycle the sink stalls a full output.
module ast_packet_arbiter #(
  parameter int DATA_W    = 64,
  parameter int EMPTY_W   = (DATA_W / 8 > 1) ? $clog2(DATA_W / 8) : 1,
  parameter int CHANNEL_W = 10,
  parameter int N_SRC     = 4,
  parameter int SRC_W     = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                               clk_i,
  input  logic                               arst_i,
  input  logic [N_SRC-1:0][DATA_W-1:0]       ast_data_i,
  input  logic [N_SRC-1:0]                   ast_startofpacket_i,
  input  logic [N_SRC-1:0]                   ast_endofpacket_i,
  input  logic [N_SRC-1:0]                   ast_valid_i,
  input  logic [N_SRC-1:0][EMPTY_W-1:0]      ast_empty_i,
  input  logic [N_SRC-1:0][CHANNEL_W-1:0]    ast_channel_i,
  output logic [N_SRC-1:0]                   ast_ready_o,
  output logic [DATA_W-1:0]                  ast_data_o,
  output logic                               ast_startofpacket_o,
  output logic                               ast_endofpacket_o,
  output logic                               ast_valid_o,
  output logic [EMPTY_W-1:0]                 ast_empty_o,
  output logic [CHANNEL_W-1:0]               ast_channel_o,
  input  logic                               ast_ready_i,
  output logic [SRC_W-1:0]                   ast_src_o,
  output logic                               drop_o
);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e              state_q, state_d;
  logic [SRC_W-1:0]    grant_q, grant_d;
  logic [SRC_W-1:0]    last_grant_q, last_grant_d;

  logic [DATA_W-1:0]    data_q, data_d;
  logic                 sop_q, sop_d;
  logic                 eop_q, eop_d;
  logic                 valid_q, valid_d;
  logic [EMPTY_W-1:0]   empty_q, empty_d;
  logic [CHANNEL_W-1:0] channel_q, channel_d;
  logic [SRC_W-1:0]     src_q, src_d;
  logic                 drop_q, drop_d;

  logic                 req_found;
  logic [SRC_W-1:0]     req_idx;
  logic [SRC_W-1:0]     arb_cand;
  logic [N_SRC-1:0]     drop_vec;
  logic [N_SRC-1:0]     ready_vec;
  logic                 grant_rdy;
  logic                 load;

  // Round-robin search starting just after the previous winner.
  always_comb begin
    req_found = 1'b0;
    req_idx   = '0;
    arb_cand  = '0;
    for (int i = 1; i <= N_SRC; i++) begin
      arb_cand = SRC_W'((int'(last_grant_q) + i) % N_SRC);
      if (!req_found && ast_valid_i[arb_cand] && ast_startofpacket_i[arb_cand]) begin
        req_found = 1'b1;
        req_idx   = arb_cand;
      end
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= SRC_W'(N_SRC - 1);
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (req_found) begin
          state_d      = BUSY;
          grant_d      = req_idx;
          last_grant_d = req_idx;
        end
      end
      BUSY: begin
        if (load && ast_endofpacket_i[grant_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Mid-packet words from anyone but the owner are swallowed; waiting SOPs are not.
  always_comb begin
    drop_vec  = '0;
    grant_rdy = 1'b0;
    for (int k = 0; k < N_SRC; k++) begin
      if (ast_valid_i[k] && !ast_startofpacket_i[k] &&
          !(state_q == BUSY && grant_q == SRC_W'(k))) begin
        drop_vec[k] = 1'b1;
      end
    end
    if (state_q == BUSY) begin
      grant_rdy = !valid_q || ast_ready_i;
    end
    ready_vec = drop_vec;
    if (state_q == BUSY) begin
      ready_vec[grant_q] = grant_rdy;
    end
    load = (state_q == BUSY) && ast_valid_i[grant_q] && grant_rdy;
  end

  always_comb begin
    data_d    = data_q;
    sop_d     = sop_q;
    eop_d     = eop_q;
    valid_d   = valid_q;
    empty_d   = empty_q;
    channel_d = channel_q;
    src_d     = src_q;
    if (load) begin
      data_d    = ast_data_i[grant_q];
      sop_d     = ast_startofpacket_i[grant_q];
      eop_d     = ast_endofpacket_i[grant_q];
      valid_d   = 1'b1;
      empty_d   = ast_empty_i[grant_q];
      channel_d = ast_channel_i[grant_q];
      src_d     = grant_q;
    end else if (ast_ready_i) begin
      data_d    = '0;
      sop_d     = 1'b0;
      eop_d     = 1'b0;
      valid_d   = 1'b0;
      empty_d   = '0;
      channel_d = '0;
      src_d     = '0;
    end
    drop_d = |drop_vec;
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      data_q    <= '0;
      sop_q     <= 1'b0;
      eop_q     <= 1'b0;
      valid_q   <= 1'b0;
      empty_q   <= '0;
      channel_q <= '0;
      src_q     <= '0;
      drop_q    <= 1'b0;
    end else begin
      data_q    <= data_d;
      sop_q     <= sop_d;
      eop_q     <= eop_d;
      valid_q   <= valid_d;
      empty_q   <= empty_d;
      channel_q <= channel_d;
      src_q     <= src_d;
      drop_q    <= drop_d;
    end
  end

  // Ready is held low for the whole reset so no word is consumed while the block is held.
  assign ast_ready_o         = arst_i ? '0 : ready_vec;
  assign ast_data_o          = data_q;
  assign ast_startofpacket_o = sop_q;
  assign ast_endofpacket_o   = eop_q;
  assign ast_valid_o         = valid_q;
  assign ast_empty_o         = empty_q;
  assign ast_channel_o       = channel_q;
  assign ast_src_o           = src_q;
  assign drop_o              = drop_q;

endmodule
